// File: rtl/fp_unpack.sv
// IEEE-754 word decoder: sign, unbiased exponent, significand with explicit hidden bit and one-hot class.
// Subnormals are normalized one left shift per clock before the result is presented.
module fp_unpack #(
   parameter int unsigned NEXP = 8,
   parameter int unsigned NSIG = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [NEXP+NSIG:0]     inWord,
   output logic                   outValid,
   input  logic                   outReady,
   output logic                   negOut,
   output logic signed [NEXP+1:0] expOut,
   output logic [NSIG:0]          sigOut,
   output logic                   snan,
   output logic                   qnan,
   output logic                   infinity,
   output logic                   zero,
   output logic                   subnormal,
   output logic                   normal
);

   localparam int unsigned EW   = NEXP + 2;
   localparam int          BIAS = (2 ** (int'(NEXP) - 1)) - 1;
   localparam int          EMIN = 1 - BIAS;
   localparam int          EMAX = BIAS;

   localparam logic signed [EW-1:0] EXP_MIN     = EW'(EMIN);
   localparam logic signed [EW-1:0] EXP_SPECIAL = EW'(EMAX + 1);
   localparam logic signed [EW-1:0] EXP_BIAS    = EW'(BIAS);
   localparam logic signed [EW-1:0] EXP_ONE     = EW'(1);

   // class vector order: {snan, qnan, infinity, zero, subnormal, normal}
   localparam logic [5:0] CLS_SNAN = 6'b100000;
   localparam logic [5:0] CLS_QNAN = 6'b010000;
   localparam logic [5:0] CLS_INF  = 6'b001000;
   localparam logic [5:0] CLS_ZERO = 6'b000100;
   localparam logic [5:0] CLS_SUB  = 6'b000010;
   localparam logic [5:0] CLS_NORM = 6'b000001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      HOLD = 2'd2
   } stateT;

   stateT                 state, stateNext;
   logic                  outValidNext;
   logic                  negNext;
   logic signed [EW-1:0]  expNext;
   logic [NSIG:0]         sigNext;
   logic [5:0]            clsReg, clsNext;

   logic [NEXP-1:0]       eField;
   logic [NSIG-1:0]       fField;
   logic signed [EW-1:0]  dExp;
   logic [NSIG:0]         dSig;
   logic [5:0]            dCls;
   logic                  dToNorm;
   logic                  accept;

   assign eField  = inWord[NEXP+NSIG-1:NSIG];
   assign fField  = inWord[NSIG-1:0];
   assign inReady = (state == IDLE) | ((state == HOLD) & outReady);
   assign accept  = inValid & inReady;
   assign {snan, qnan, infinity, zero, subnormal, normal} = clsReg;

   // Field decode of the word on the input bus
   always_comb begin
      dExp    = '0;
      dSig    = '0;
      dCls    = '0;
      dToNorm = 1'b0;
      if (eField == '0) begin
         dExp = EXP_MIN;
         if (fField == '0) begin
            dCls = CLS_ZERO;
         end else begin
            dCls    = CLS_SUB;
            dSig    = {1'b0, fField};
            dToNorm = 1'b1;
         end
      end else if (eField == '1) begin
         dExp = EXP_SPECIAL;
         if (fField == '0) begin
            dCls = CLS_INF;
         end else begin
            dCls = fField[NSIG-1] ? CLS_QNAN : CLS_SNAN;
            dSig = {1'b0, fField};
         end
      end else begin
         dCls = CLS_NORM;
         dExp = signed'(EW'(eField)) - EXP_BIAS;
         dSig = {1'b1, fField};
      end
   end

   // Next-state and next-output logic
   always_comb begin
      stateNext    = state;
      outValidNext = outValid;
      negNext      = negOut;
      expNext      = expOut;
      sigNext      = sigOut;
      clsNext      = clsReg;
      case (state)
         IDLE, HOLD: begin
            if (accept) begin
               negNext      = inWord[NEXP+NSIG];
               expNext      = dExp;
               sigNext      = dSig;
               clsNext      = dCls;
               stateNext    = dToNorm ? NORM : HOLD;
               outValidNext = ~dToNorm;
            end else if (state == HOLD && outReady) begin
               stateNext    = IDLE;
               outValidNext = 1'b0;
            end
         end
         NORM: begin
            if (!sigOut[NSIG]) begin
               sigNext = {sigOut[NSIG-1:0], 1'b0};
               expNext = expOut - EXP_ONE;
            end
            if (sigNext[NSIG]) begin
               stateNext    = HOLD;
               outValidNext = 1'b1;
            end
         end
         default: begin
            stateNext    = IDLE;
            outValidNext = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         outValid <= 1'b0;
         negOut   <= 1'b0;
         expOut   <= '0;
         sigOut   <= '0;
         clsReg   <= '0;
      end else begin
         state    <= stateNext;
         outValid <= outValidNext;
         negOut   <= negNext;
         expOut   <= expNext;
         sigOut   <= sigNext;
         clsReg   <= clsNext;
      end
   end

endmodule

// File: tb/tb_fp_unpack.sv
// Self-checking bench for fp_unpack (single precision) against a plain-arithmetic decode model.
module tb_fp_unpack;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               inValid = 1'b0;
   logic               inReady;
   logic [31:0]        inWord = '0;
   logic               outValid;
   logic               outReady = 1'b0;
   logic               negOut;
   logic signed [9:0]  expOut;
   logic [23:0]        sigOut;
   logic               snan, qnan, infinity, zero, subnormal, normal;
   logic [40:0]        obs;

   int nCompared = 0;
   int nMismatched = 0;

   fp_unpack #(.NEXP(8), .NSIG(23)) dut (
      .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inWord(inWord),
      .outValid(outValid), .outReady(outReady), .negOut(negOut), .expOut(expOut),
      .sigOut(sigOut), .snan(snan), .qnan(qnan), .infinity(infinity), .zero(zero),
      .subnormal(subnormal), .normal(normal)
   );

   always #5 clk = ~clk;

   assign obs = {negOut, expOut, sigOut, snan, qnan, infinity, zero, subnormal, normal};

   // Decoded value from the IEEE rules: {sign, exponent, significand, class}
   function automatic logic [40:0] modelOut(input logic [31:0] w);
      int e, f, ex, s;
      logic [5:0] cls;
      e = int'(w[30:23]);
      f = int'(w[22:0]);
      if (e == 0 && f == 0) begin
         cls = 6'b000100; ex = -126; s = 0;
      end else if (e == 0) begin
         ex = -126;
         while (f < (1 << 23)) begin
            f = f * 2;
            ex = ex - 1;
         end
         cls = 6'b000010; s = f;
      end else if (e == 255 && f == 0) begin
         cls = 6'b001000; ex = 128; s = 0;
      end else if (e == 255) begin
         cls = w[22] ? 6'b010000 : 6'b100000; ex = 128; s = f;
      end else begin
         cls = 6'b000001; ex = e - 127; s = f + (1 << 23);
      end
      return {w[31], 10'(ex), 24'(s), cls};
   endfunction

   // Cycles from accept edge to first valid output
   function automatic int modelLat(input logic [31:0] w);
      int f, n;
      f = int'(w[22:0]);
      n = 1;
      if (w[30:23] == 8'd0 && f != 0) begin
         while (f < (1 << 23)) begin
            f = f * 2;
            n++;
         end
      end
      return n;
   endfunction

   function automatic logic [31:0] randWord();
      logic [31:0] w;
      logic [22:0] f;
      int c;
      c = int'($urandom_range(0, 5));
      f = 23'($urandom);
      w[31] = 1'($urandom);
      case (c)
         0: begin w[30:23] = 8'd0;   w[22:0] = '0; end
         1: begin
            f = 23'(($urandom | 1) >> $urandom_range(9, 31));
            if (f == '0) f = 23'd1;
            w[30:23] = 8'd0; w[22:0] = f;
         end
         2: begin w[30:23] = 8'($urandom_range(1, 254)); w[22:0] = f; end
         3: begin w[30:23] = 8'hFF;  w[22:0] = '0; end
         4: begin w[30:23] = 8'hFF;  w[22:0] = f | 23'h400000; end
         default: begin
            f = f & 23'h3FFFFF;
            if (f == '0) f = 23'd5;
            w[30:23] = 8'hFF; w[22:0] = f;
         end
      endcase
      return w;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      nCompared++;
      if (outValid !== 1'b0 || obs !== 41'd0) begin
         nMismatched++;
         $display("FAIL reset_outputs: got valid=%0b obs=%h want valid=0 obs=0", outValid, obs);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      nCompared++;
      if (inReady !== 1'b1) begin
         nMismatched++;
         $display("FAIL reset_inReady: got %0b want 1", inReady);
      end
   endtask

   task automatic test_decode();
      logic [31:0] words[$];
      logic [31:0] w;
      int lat;
      words = '{32'h3F800000, 32'h00000001, 32'h00400000, 32'hFF800000,
                32'h7FC00001, 32'h7F800001, 32'h80000000, 32'h007FFFFF, 32'h00800000};
      for (int i = 0; i < 40; i++) words.push_back(randWord());
      foreach (words[k]) begin
         w = words[k];
         @(negedge clk);
         inWord = w;
         inValid = 1'b1;
         outReady = 1'b0;
         @(posedge clk);
         #1;
         inValid = 1'b0;
         lat = 1;
         while (!outValid && lat < 40) begin
            nCompared++;
            if (inReady !== 1'b0) begin
               nMismatched++;
               $display("FAIL norm_inReady: word %h cycle %0d got %0b want 0", w, lat, inReady);
            end
            @(posedge clk);
            #1;
            lat++;
         end
         nCompared++;
         if (lat !== modelLat(w) || outValid !== 1'b1) begin
            nMismatched++;
            $display("FAIL latency: word %h got %0d (valid=%0b) want %0d", w, lat, outValid, modelLat(w));
         end
         nCompared++;
         if (obs !== modelOut(w)) begin
            nMismatched++;
            $display("FAIL decode: word %h got %h want %h", w, obs, modelOut(w));
         end
         outReady = 1'b1;
         @(posedge clk);
         #1;
         outReady = 1'b0;
         nCompared++;
         if (outValid !== 1'b0 || inReady !== 1'b1) begin
            nMismatched++;
            $display("FAIL release: word %h got valid=%0b ready=%0b want 0/1", w, outValid, inReady);
         end
      end
   endtask

   task automatic test_hold_stall();
      logic [40:0] want;
      want = modelOut(32'h40490FDB);
      @(negedge clk);
      inWord = 32'h40490FDB;
      inValid = 1'b1;
      outReady = 1'b0;
      @(posedge clk);
      #1;
      inWord = 32'h3F800000;
      for (int c = 0; c < 5; c++) begin
         nCompared++;
         if (outValid !== 1'b1 || inReady !== 1'b0 || obs !== want) begin
            nMismatched++;
            $display("FAIL hold_stall: cycle %0d got valid=%0b ready=%0b obs=%h want 1/0/%h",
                     c, outValid, inReady, obs, want);
         end
         @(posedge clk);
         #1;
      end
      inValid = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      nCompared++;
      if (outValid !== 1'b0) begin
         nMismatched++;
         $display("FAIL hold_release: got valid=%0b want 0", outValid);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[4];
      w = '{32'h40490FDB, 32'hC2280000, 32'h3F800000, 32'h00800000};
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         inWord = w[i];
         inValid = 1'b1;
         nCompared++;
         if (inReady !== 1'b1) begin
            nMismatched++;
            $display("FAIL b2b_ready: word %0d got %0b want 1", i, inReady);
         end
         @(posedge clk);
         #1;
         nCompared++;
         if (outValid !== 1'b1 || obs !== modelOut(w[i])) begin
            nMismatched++;
            $display("FAIL b2b_result: word %0d got valid=%0b obs=%h want 1/%h", i, outValid, obs, modelOut(w[i]));
         end
      end
      @(negedge clk);
      inValid = 1'b0;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      nCompared++;
      if (outValid !== 1'b0) begin
         nMismatched++;
         $display("FAIL b2b_drain: got valid=%0b want 0", outValid);
      end
   endtask

   task automatic test_reset_mid_flight();
      // reset during normalization
      @(negedge clk);
      inWord = 32'h00000001;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      nCompared++;
      if (outValid !== 1'b0 || obs !== 41'd0) begin
         nMismatched++;
         $display("FAIL rst_norm: got valid=%0b obs=%h want 0/0", outValid, obs);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      nCompared++;
      if (inReady !== 1'b1) begin
         nMismatched++;
         $display("FAIL rst_norm_idle: got inReady=%0b want 1", inReady);
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         nCompared++;
         if (outValid !== 1'b0) begin
            nMismatched++;
            $display("FAIL rst_norm_ghost: cycle %0d got valid=%0b want 0", c, outValid);
         end
      end
      // reset while a result is held
      @(negedge clk);
      inWord = 32'hBF800000;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
      nCompared++;
      if (outValid !== 1'b1) begin
         nMismatched++;
         $display("FAIL rst_hold_pre: got valid=%0b want 1", outValid);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      nCompared++;
      if (outValid !== 1'b0 || obs !== 41'd0) begin
         nMismatched++;
         $display("FAIL rst_hold: got valid=%0b obs=%h want 0/0", outValid, obs);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      nCompared++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
         nMismatched++;
         $display("FAIL rst_hold_after: got valid=%0b ready=%0b want 0/1", outValid, inReady);
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_hold_stall();
      test_back_to_back();
      test_reset_mid_flight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
